// File: rtl/mem_stage_if.sv
// Handshake and data bundle between execute, the memory stage, write-back and decode.
// master = the environment driving execute/write-back side; slave = mem_stage.
interface mem_stage_if;
  logic        EX_to_MEM_valid;
  logic [73:0] EX_to_MEM_bus;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        MEM_allowin;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [37:0] MEM_fwd_bus;
  logic        MEM_is_load;

  modport master (
    output EX_to_MEM_valid, EX_to_MEM_bus, data_sram_rdata, WB_allowin,
    input  MEM_allowin, MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_bus, MEM_is_load
  );

  modport slave (
    input  EX_to_MEM_valid, EX_to_MEM_bus, data_sram_rdata, WB_allowin,
    output MEM_allowin, MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_bus, MEM_is_load
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bundle, extends SRAM load data
// by load type and feeds write-back plus decode forwarding / load-use information.
module mem_stage (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave io
);
  // Handshake: a stage may advance when the consumer asserts allowin in the same
  // cycle the producer asserts valid; both sides sample on the rising clk edge.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  logic        r_mem_valid;
  logic [73:0] r_bus;

  logic        w_readygo;
  logic        w_allowin;
  logic [31:0] w_pc;
  logic        w_res_from_mem;
  logic [2:0]  w_mem_op;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_alu_result;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mem_result;
  logic [31:0] w_final_result;

  assign w_readygo = 1'b1;
  assign w_allowin = !r_mem_valid || (w_readygo && io.WB_allowin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
      r_bus       <= '0;
    end else if (w_allowin) begin
      r_mem_valid <= io.EX_to_MEM_valid;
      if (io.EX_to_MEM_valid) begin
        r_bus <= io.EX_to_MEM_bus;
      end
    end
  end

  assign w_pc           = r_bus[73:42];
  assign w_res_from_mem = r_bus[41];
  assign w_mem_op       = r_bus[40:38];
  assign w_rf_we        = r_bus[37];
  assign w_rf_waddr     = r_bus[36:32];
  assign w_alu_result   = r_bus[31:0];
  assign w_off          = w_alu_result[1:0];

  // SRAM data arrives one cycle after execute issued the request, so it is used raw here.
  always_comb begin
    w_byte = io.data_sram_rdata[7:0];
    case (w_off)
      2'd0: w_byte = io.data_sram_rdata[7:0];
      2'd1: w_byte = io.data_sram_rdata[15:8];
      2'd2: w_byte = io.data_sram_rdata[23:16];
      2'd3: w_byte = io.data_sram_rdata[31:24];
      default: w_byte = io.data_sram_rdata[7:0];
    endcase
    w_half = w_alu_result[1] ? io.data_sram_rdata[31:16] : io.data_sram_rdata[15:0];
    w_mem_result = io.data_sram_rdata;
    case (w_mem_op)
      LD_B:    w_mem_result = {{24{w_byte[7]}}, w_byte};
      LD_H:    w_mem_result = {{16{w_half[15]}}, w_half};
      LD_BU:   w_mem_result = {24'd0, w_byte};
      LD_HU:   w_mem_result = {16'd0, w_half};
      default: w_mem_result = io.data_sram_rdata;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_mem_result : w_alu_result;

  assign io.MEM_allowin     = w_allowin;
  assign io.MEM_to_WB_valid = r_mem_valid && w_readygo;
  // rf_we goes out ungated; write-back qualifies it with its own valid.
  assign io.MEM_to_WB_bus   = {w_pc, w_rf_we, w_rf_waddr, w_final_result};
  assign io.MEM_fwd_bus     = {r_mem_valid && w_rf_we, w_rf_waddr, w_final_result};
  assign io.MEM_is_load     = r_mem_valid && w_res_from_mem;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load-extension vector table plus handshake,
// back-pressure, bubble and asynchronous reset sequences.
module tb_mem_stage;
  logic clk;
  logic resetn;
  mem_stage_if io ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (io)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int errors = 0;
  int checks = 0;
  logic [69:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        res;
    logic [2:0]  op;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] make_ex(input logic [31:0] pc, input logic res,
                                          input logic [2:0] op, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] alu);
    return {pc, res, op, we, waddr, alu};
  endfunction

  // driver: present a bundle at the falling edge, leave it for the next rising edge
  task automatic drive(input logic valid, input logic [73:0] bus, input logic [31:0] rdata,
                       input logic wb_allowin);
    @(negedge clk);
    io.EX_to_MEM_valid = valid;
    io.EX_to_MEM_bus   = bus;
    io.data_sram_rdata = rdata;
    io.WB_allowin      = wb_allowin;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [69:0] exp_bus;
    logic [69:0] held_bus;
    logic [69:0] exp_b;
    logic [73:0] pending;

    vecs[0]  = '{32'h1C000010, 1'b0, 3'b000, 5'd5,  32'h12345678, 32'h80FF7F01, 32'h12345678};
    vecs[1]  = '{32'h1C000014, 1'b1, 3'b000, 5'd6,  32'h00001003, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[2]  = '{32'h1C000018, 1'b1, 3'b100, 5'd7,  32'h00001003, 32'h80FF7F01, 32'h00000080};
    vecs[3]  = '{32'h1C00001C, 1'b1, 3'b000, 5'd8,  32'h00001001, 32'h80FF7F01, 32'h0000007F};
    vecs[4]  = '{32'h1C000020, 1'b1, 3'b001, 5'd9,  32'h00001002, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[5]  = '{32'h1C000024, 1'b1, 3'b101, 5'd10, 32'h00001000, 32'h80FF7F01, 32'h00007F01};
    vecs[6]  = '{32'h1C000028, 1'b1, 3'b010, 5'd11, 32'h00001002, 32'h80FF7F01, 32'h80FF7F01};
    vecs[7]  = '{32'h1C00002C, 1'b1, 3'b000, 5'd12, 32'h00001000, 32'h80FF7F01, 32'h00000001};
    vecs[8]  = '{32'h1C000030, 1'b1, 3'b000, 5'd13, 32'h00001002, 32'h80FF7F01, 32'hFFFFFFFF};
    vecs[9]  = '{32'h1C000034, 1'b1, 3'b001, 5'd14, 32'h00001003, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[10] = '{32'h1C000038, 1'b1, 3'b101, 5'd15, 32'h00001002, 32'h80FF7F01, 32'h000080FF};
    vecs[11] = '{32'h1C00003C, 1'b1, 3'b001, 5'd16, 32'h00001000, 32'h80FF7F01, 32'h00007F01};
    vecs[12] = '{32'h1C000040, 1'b1, 3'b011, 5'd17, 32'h00001001, 32'h80FF7F01, 32'h80FF7F01};
    vecs[13] = '{32'h1C000044, 1'b1, 3'b110, 5'd18, 32'h00001003, 32'hA5C3E1F0, 32'hA5C3E1F0};
    vecs[14] = '{32'h1C000048, 1'b1, 3'b111, 5'd19, 32'h00001002, 32'h0123ABCD, 32'h0123ABCD};
    vecs[15] = '{32'h1C00004C, 1'b0, 3'b000, 5'd31, 32'hCAFEF00D, 32'h80FF7F01, 32'hCAFEF00D};

    resetn             = 1'b0;
    io.EX_to_MEM_valid = 1'b0;
    io.EX_to_MEM_bus   = '0;
    io.data_sram_rdata = '0;
    io.WB_allowin      = 1'b1;
    #12;
    check("rst_allowin", io.MEM_allowin, 1);
    check("rst_valid",   io.MEM_to_WB_valid, 0);
    check("rst_bus",     io.MEM_to_WB_bus, 0);
    check("rst_fwd",     io.MEM_fwd_bus, 0);
    check("rst_is_load", io.MEM_is_load, 0);
    @(negedge clk);
    resetn = 1'b1;

    // table of single instructions, all with rf_we = 1
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, make_ex(vecs[i].pc, vecs[i].res, vecs[i].op, 1'b1, vecs[i].waddr, vecs[i].alu),
            vecs[i].rdata, 1'b1);
      edge_sample();
      exp_bus = {vecs[i].pc, 1'b1, vecs[i].waddr, vecs[i].exp};
      check($sformatf("vec%0d_valid", i), io.MEM_to_WB_valid, 1);
      check($sformatf("vec%0d_bus", i), io.MEM_to_WB_bus, exp_bus);
      check($sformatf("vec%0d_fwd", i), io.MEM_fwd_bus, {32'd0, 1'b1, vecs[i].waddr, vecs[i].exp});
      check($sformatf("vec%0d_is_load", i), io.MEM_is_load, vecs[i].res);
    end

    // rf_we = 0 must drop fwd_we and the bus rf_we bit
    drive(1'b1, make_ex(32'h1C000050, 1'b0, 3'b000, 1'b0, 5'd3, 32'h00000042), 32'h0, 1'b1);
    edge_sample();
    check("nowe_bus", io.MEM_to_WB_bus, {32'h1C000050, 1'b0, 5'd3, 32'h00000042});
    check("nowe_fwd", io.MEM_fwd_bus, {32'd0, 1'b0, 5'd3, 32'h00000042});

    // back-pressure with a load held in MEM
    drive(1'b1, make_ex(32'h1C000100, 1'b1, 3'b000, 1'b1, 5'd4, 32'h00002003), 32'h80FF7F01, 1'b1);
    edge_sample();
    held_bus = {32'h1C000100, 1'b1, 5'd4, 32'hFFFFFF80};
    check("bp_load_bus", io.MEM_to_WB_bus, held_bus);
    pending = make_ex(32'h1C000104, 1'b0, 3'b000, 1'b1, 5'd9, 32'h0BADBEEF);
    drive(1'b1, pending, 32'h80FF7F01, 1'b0);
    #1;
    check("bp_allowin_low", io.MEM_allowin, 0);
    for (int c = 0; c < 3; c++) begin
      edge_sample();
      check($sformatf("bp%0d_allowin", c), io.MEM_allowin, 0);
      check($sformatf("bp%0d_valid", c), io.MEM_to_WB_valid, 1);
      check($sformatf("bp%0d_bus", c), io.MEM_to_WB_bus, held_bus);
      check($sformatf("bp%0d_is_load", c), io.MEM_is_load, 1);
    end
    drive(1'b1, pending, 32'h80FF7F01, 1'b1);
    #1;
    check("bp_release_allowin", io.MEM_allowin, 1);
    edge_sample();
    check("bp_release_bus", io.MEM_to_WB_bus, {32'h1C000104, 1'b1, 5'd9, 32'h0BADBEEF});
    check("bp_release_is_load", io.MEM_is_load, 0);

    // four back-to-back bundles, scoreboard in order
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, make_ex(32'h1C000200 + 32'(k * 4), 1'b0, 3'b010, 1'b1, 5'(20 + k),
                          32'h11111111 * 32'(k + 1)), 32'h0, 1'b1);
      exp_q.push_back({32'h1C000200 + 32'(k * 4), 1'b1, 5'(20 + k), 32'h11111111 * 32'(k + 1)});
      edge_sample();
      check($sformatf("b2b%0d_valid", k), io.MEM_to_WB_valid, 1);
      check($sformatf("b2b%0d_bus", k), io.MEM_to_WB_bus, exp_q.pop_front());
    end
    drive(1'b0, '0, 32'h0, 1'b1);
    edge_sample();
    check("drain_valid", io.MEM_to_WB_valid, 0);
    check("drain_fwd_we", io.MEM_fwd_bus[37], 0);
    check("drain_allowin", io.MEM_allowin, 1);

    // one-cycle bubble between two instructions
    exp_b = {32'h1C000300, 1'b1, 5'd1, 32'h00000AAA};
    drive(1'b1, make_ex(32'h1C000300, 1'b0, 3'b000, 1'b1, 5'd1, 32'h00000AAA), 32'h0, 1'b1);
    edge_sample();
    check("bub_a_valid", io.MEM_to_WB_valid, 1);
    drive(1'b0, make_ex(32'h1C0003FC, 1'b1, 3'b000, 1'b1, 5'd30, 32'hFFFFFFFF), 32'h0, 1'b1);
    edge_sample();
    check("bub_valid", io.MEM_to_WB_valid, 0);
    check("bub_fwd_we", io.MEM_fwd_bus[37], 0);
    check("bub_bus_held", io.MEM_to_WB_bus, exp_b);
    drive(1'b1, make_ex(32'h1C000304, 1'b1, 3'b100, 1'b1, 5'd2, 32'h00000001), 32'h80FF7F01, 1'b1);
    edge_sample();
    check("bub_b_valid", io.MEM_to_WB_valid, 1);
    check("bub_b_bus", io.MEM_to_WB_bus, {32'h1C000304, 1'b1, 5'd2, 32'h0000007F});

    // asynchronous reset with a load held in MEM
    drive(1'b1, make_ex(32'h1C000400, 1'b1, 3'b010, 1'b1, 5'd7, 32'h0), 32'h5555AAAA, 1'b0);
    edge_sample();
    check("arst_pre_valid", io.MEM_to_WB_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", io.MEM_to_WB_valid, 0);
    check("arst_allowin", io.MEM_allowin, 1);
    check("arst_bus", io.MEM_to_WB_bus, 0);
    check("arst_fwd", io.MEM_fwd_bus, 0);
    check("arst_is_load", io.MEM_is_load, 0);
    drive(1'b1, make_ex(32'h1C000500, 1'b0, 3'b000, 1'b1, 5'd8, 32'h76543210), 32'h0, 1'b1);
    resetn = 1'b1;
    edge_sample();
    check("post_rst_valid", io.MEM_to_WB_valid, 1);
    check("post_rst_bus", io.MEM_to_WB_bus, {32'h1C000500, 1'b1, 5'd8, 32'h76543210});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting between the execute stage and the write-back stage. It registers the execute-stage bundle under a valid/allowin handshake and selects load data from the synchronous data SRAM read port. It extends that data according to load type and emits the 70-bit bundle `{pc, rf_we, rf_waddr, final_result}` that write-back consumes. It also drives forwarding and load-use information back to decode.

## Interface
Parameters: none.

- clk  input  1  single clock; all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- EX_to_MEM_valid  input  1  execute stage holds a valid instruction offered to MEM
- EX_to_MEM_bus  input  74  fields, MSB first:
  - pc[31:0]
  - res_from_mem
  - mem_op[2:0]
  - rf_we
  - rf_waddr[4:0]
  - alu_result[31:0]
- data_sram_rdata  input  32  SRAM read data for the request issued by execute one cycle earlier
- WB_allowin  input  1  write-back can accept a bundle this cycle
- MEM_allowin  output  1  MEM accepts a new bundle this cycle
- MEM_to_WB_valid  output  1  bundle on MEM_to_WB_bus is valid
- MEM_to_WB_bus  output  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
- MEM_fwd_bus  output  38  {fwd_we, rf_waddr[4:0], final_result[31:0]} for decode bypass
- MEM_is_load  output  1  MEM_valid && res_from_mem; decode uses it for load-use detection

## Operation
- State:
  - MEM_valid flag
  - 74-bit bus register holding pc, res_from_mem, mem_op, rf_we, rf_waddr and alu_result
- Handshake:
  - MEM_readygo = 1 (constant)
  - MEM_allowin = !MEM_valid || (MEM_readygo && WB_allowin)
  - MEM_to_WB_valid = MEM_valid && MEM_readygo
- Capture: when MEM_allowin = 1:
  - MEM_valid <= EX_to_MEM_valid
  - bus register <= EX_to_MEM_bus, only if EX_to_MEM_valid = 1; otherwise the bus register holds its value
- Hold: when MEM_allowin = 0, all state holds.
- Load select uses off = alu_result[1:0]:
  - byte = rdata[8*off+7 : 8*off]
  - half = alu_result[1] ? rdata[31:16] : rdata[15:0]
  - alu_result[0] is ignored for halfwords; no alignment check in this block
- mem_op encoding:
  - 000 LD_B: sign-extend byte
  - 001 LD_H: sign-extend half
  - 010 LD_W: full word, offset ignored
  - 100 LD_BU: zero-extend byte
  - 101 LD_HU: zero-extend half
  - 011, 110, 111: reserved, treated as LD_W
- final_result = res_from_mem ? mem_result : alu_result.
- MEM_to_WB_bus carries the registered rf_we ungated; write-back gates it with its valid.
- fwd_we = MEM_valid && rf_we.
- Forwarding of a load result is legal. Decode still stalls on MEM_is_load only if its SRAM-timing policy requires it; that is not this block's concern.
- data_sram_rdata is used combinationally and never registered here. Outputs are valid only in the cycle MEM_valid = 1 following the SRAM request.

## Timing
- Reset (resetn = 0, asynchronous):
  - MEM_valid = 0 and bus register = 0 immediately
  - therefore MEM_to_WB_valid = 0, MEM_is_load = 0, fwd_we = 0
  - MEM_allowin = 1
  - MEM_to_WB_bus has pc = 0, rf_we = 0, waddr = 0, final_result = 0
- Reset deasserts synchronously to clk (done externally). The first capture is possible on the first rising edge with resetn = 1.
- Reset mid-operation discards the held instruction; no partial write-back is emitted.
- Latency: one cycle from EX_to_MEM_valid && MEM_allowin to MEM_to_WB_valid.
- Throughput: one instruction per cycle when WB_allowin = 1.
- Simultaneous accept and drain (MEM_valid = 1, WB_allowin = 1, EX_to_MEM_valid = 1): the new bundle replaces the old on the same edge, with no bubble.
- Drain without refill (WB_allowin = 1, EX_to_MEM_valid = 0): MEM_valid falls to 0 at the next edge.
- Back-pressure (MEM_valid = 1, WB_allowin = 0): state frozen, MEM_allowin = 0, and outputs stable for every stalled cycle. The execute stage must hold its SRAM response; this block does not re-sample it.

## Test plan
- Reset: assert resetn = 0 mid-stream with MEM_valid = 1 -> MEM_to_WB_valid = 0, MEM_allowin = 1, MEM_to_WB_bus = 0 without waiting for a clock edge.
- ALU pass-through:
  - stimulus: pc = 0x1C000010, res_from_mem = 0, rf_we = 1, waddr = 5, alu_result = 0x12345678
  - response next cycle: MEM_to_WB_bus = {0x1C000010, 1, 5, 0x12345678}, fwd bus = {1, 5, 0x12345678}
- Load extension with rdata = 0x80FF7F01:
  - LD_B off 3 -> 0xFFFFFF80
  - LD_BU off 3 -> 0x00000080
  - LD_B off 1 -> 0x0000007F
  - LD_H off 2 -> 0xFFFF80FF
  - LD_HU off 0 -> 0x00007F01
  - LD_W off 2 -> 0x80FF7F01
- Back-pressure: hold WB_allowin = 0 for 3 cycles with a load in MEM -> MEM_allowin = 0 throughout, bus unchanged, MEM_is_load = 1; release -> next EX bundle captured on that edge.
- Back-to-back: 4 consecutive valid bundles with WB_allowin = 1 -> 4 consecutive MEM_to_WB_valid cycles, in order, no bubbles.
- Bubble: EX_to_MEM_valid = 0 for one cycle between instructions -> exactly one cycle with MEM_to_WB_valid = 0 and fwd_we = 0.
